alu_seq: RTL

Parametrised, registered successor to the 16-bit combinational ALU. It accepts one operation per valid/ready handshake and registers every result with a one-cycle output-valid pulse. Division runs on a multi-cycle restoring divider, so the block sits between an operand source and a result consumer as a pipelined, back-pressuring arithmetic unit.

---
 rtl/alu_seq_if.sv | 38 +++
 rtl/alu_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
//------------------------------------------------------------------------------
// Module      : alu_seq_if
// Description : Operand/result handshake bundle for alu_seq.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_FUN;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] ALU_OUT;
    logic             OUT_VALID;
    logic             Arith_flag;
    logic             Logic_flag;
    logic             CMP_flag;
    logic             Shift_flag;
    logic             CARRY;
    logic             DIV0;

    modport master (
        output A, B, ALU_FUN, IN_VALID,
        input  IN_READY, ALU_OUT, OUT_VALID, Arith_flag, Logic_flag,
               CMP_flag, Shift_flag, CARRY, DIV0
    );

    modport slave (
        input  A, B, ALU_FUN, IN_VALID,
        output IN_READY, ALU_OUT, OUT_VALID, Arith_flag, Logic_flag,
               CMP_flag, Shift_flag, CARRY, DIV0
    );
endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
//------------------------------------------------------------------------------
// Module      : alu_seq
// Description : Registered handshake ALU; optional restoring divider when
//               ALU_DIV_EN is defined (otherwise opcode 0011 reports DIV0).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_seq #(
    parameter int WIDTH = 16
) (
    input  wire logic  CLK,
    input  wire logic  RST,
    alu_seq_if.slave   bus
);

    // Flag vector order: {Arith, Logic, CMP, Shift}
    localparam logic [3:0] c_flg_arith = 4'b1000;
    localparam logic [3:0] c_flg_logic = 4'b0100;
    localparam logic [3:0] c_flg_cmp   = 4'b0010;
    localparam logic [3:0] c_flg_shift = 4'b0001;

    logic [WIDTH-1:0]   r_alu_out;
    logic [3:0]         r_flags;
    logic               r_carry;
    logic               r_div0;
    logic               r_out_valid;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_res;
    logic [3:0]         w_flags;
    logic               w_carry;
    logic               w_div0;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_start_div;

    always_comb begin
        w_sum   = {1'b0, bus.A} + {1'b0, bus.B};
        w_diff  = {1'b0, bus.A} - {1'b0, bus.B};
        w_prod  = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
        w_res   = '0;
        w_flags = 4'b0000;
        w_carry = 1'b0;
        w_div0  = 1'b0;
        case (bus.ALU_FUN)
            4'b0000: begin w_res = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  w_flags = c_flg_arith; end
            4'b0001: begin w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; w_flags = c_flg_arith; end
            4'b0010: begin
                w_res   = w_prod[WIDTH-1:0];
                w_carry = |w_prod[2*WIDTH-1:WIDTH];
                w_flags = c_flg_arith;
            end
            4'b0011: begin
                // Only the divide-by-zero (or divider-less) result is produced here
`ifdef ALU_DIV_EN
                w_res  = '1;
                w_div0 = (bus.B == '0);
`else
                w_res  = '0;
                w_div0 = 1'b1;
`endif
                w_flags = c_flg_arith;
            end
            4'b0100: begin w_res = bus.A & bus.B;    w_flags = c_flg_logic; end
            4'b0101: begin w_res = bus.A | bus.B;    w_flags = c_flg_logic; end
            4'b0110: begin w_res = ~(bus.A & bus.B); w_flags = c_flg_logic; end
            4'b0111: begin w_res = ~(bus.A | bus.B); w_flags = c_flg_logic; end
            4'b1000: begin w_res = bus.A ^ bus.B;    w_flags = c_flg_logic; end
            4'b1001: begin w_res = ~(bus.A ^ bus.B); w_flags = c_flg_logic; end
            4'b1010: begin w_res = (bus.A == bus.B) ? WIDTH'(1) : '0; w_flags = c_flg_cmp; end
            4'b1011: begin w_res = (bus.A >  bus.B) ? WIDTH'(2) : '0; w_flags = c_flg_cmp; end
            4'b1100: begin w_res = (bus.A <  bus.B) ? WIDTH'(3) : '0; w_flags = c_flg_cmp; end
            4'b1101: begin w_res = bus.A >> 1; w_flags = c_flg_shift; end
            4'b1110: begin w_res = bus.A << 1; w_flags = c_flg_shift; end
            default: begin w_res = '0; w_flags = 4'b0000; end
        endcase
    end

`ifdef ALU_DIV_EN
    localparam int             c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, DIV = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic               w_div_done;

    assign w_in_ready  = (r_state == IDLE);
    assign w_start_div = w_accept && (bus.ALU_FUN == 4'b0011) && (bus.B != '0);
    assign w_div_done  = (r_state == DIV) && (r_cnt == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.IN_VALID && (bus.ALU_FUN == 4'b0011) && (bus.B != '0)) w_state_next = DIV;
            DIV:     if (r_cnt == '0) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Restoring step: bit WIDTH of the trial difference is the borrow, since
    // the shifted partial remainder never exceeds twice the divisor.
    always_comb begin
        w_shift = {r_rem, r_quo[WIDTH-1]};
        w_trial = w_shift - {1'b0, r_divisor};
        if (!w_trial[WIDTH]) begin
            w_rem_next = w_trial[WIDTH-1:0];
            w_quo_next = {r_quo[WIDTH-2:0], 1'b1};
        end else begin
            w_rem_next = w_shift[WIDTH-1:0];
            w_quo_next = {r_quo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
        end else if (w_start_div) begin
            r_cnt     <= c_cnt_last;
            r_rem     <= '0;
            r_quo     <= bus.A;
            r_divisor <= bus.B;
        end else if (r_state == DIV) begin
            r_cnt <= r_cnt - 1'b1;
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
        end
    end
`else
    assign w_in_ready  = 1'b1;
    assign w_start_div = 1'b0;
`endif

    assign w_accept = bus.IN_VALID && w_in_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_alu_out   <= '0;
            r_flags     <= 4'b0000;
            r_carry     <= 1'b0;
            r_div0      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept && !w_start_div) begin
                r_alu_out   <= w_res;
                r_flags     <= w_flags;
                r_carry     <= w_carry;
                r_div0      <= w_div0;
                r_out_valid <= 1'b1;
            end
`ifdef ALU_DIV_EN
            else if (w_div_done) begin
                r_alu_out   <= w_quo_next;
                r_flags     <= c_flg_arith;
                r_carry     <= 1'b0;
                r_div0      <= 1'b0;
                r_out_valid <= 1'b1;
            end
`endif
        end
    end

    assign bus.IN_READY   = w_in_ready;
    assign bus.ALU_OUT    = r_alu_out;
    assign bus.OUT_VALID  = r_out_valid;
    assign bus.Arith_flag = r_flags[3];
    assign bus.Logic_flag = r_flags[2];
    assign bus.CMP_flag   = r_flags[1];
    assign bus.Shift_flag = r_flags[0];
    assign bus.CARRY      = r_carry;
    assign bus.DIV0       = r_div0;

endmodule

`default_nettype wire
